// File: rtl/responder_pkg.sv
// Shared definitions for the responder scoring path: default log geometry and
// the {who, score} entry layout used by the arbiter, logger and display driver.
package responder_pkg;

    localparam int unsigned DEF_ID_W    = 4;
    localparam int unsigned DEF_SCORE_W = 8;
    localparam int unsigned DEF_DEPTH   = 20;

    // Entry layout at the default widths; `who` sits in the upper bits.
    typedef struct packed {
        logic [DEF_ID_W-1:0]    who;
        logic [DEF_SCORE_W-1:0] score;
    } entry_t;

    // Concatenate an id and score into the packed entry layout.
    function automatic entry_t make_entry(logic [DEF_ID_W-1:0]    who,
                                          logic [DEF_SCORE_W-1:0] score);
        entry_t e;
        e.who   = who;
        e.score = score;
        return e;
    endfunction

endpackage

// File: rtl/score_log_mem.sv
// Log storage: DEPTH x WIDTH array with a synchronous write port and a
// registered read port. The array itself is never reset; only the read
// register is, so the logged result reads as zero after reset.
module score_log_mem
    import responder_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_ID_W + DEF_SCORE_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEF_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Write port: store the entry at the addressed slot.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read port: capture on an accepted read, otherwise hold the last entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/score_log.sv
// Record/replay log of buzzer results. Record mode appends {who, score}
// entries; replay mode returns them in arrival order, one per request.
// Command priority: clear, then rewind, then wr_en / rd_req.
module score_log
    import responder_pkg::*;
#(
    parameter int unsigned ID_W    = DEF_ID_W,
    parameter int unsigned SCORE_W = DEF_SCORE_W,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    localparam int unsigned PTR_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic                    wr_en,
    input  logic [ID_W-1:0]         who,
    input  logic [SCORE_W-1:0]      score,
    input  logic                    rd_req,
    input  logic                    rewind,
    input  logic                    clear,
    output logic [ID_W+SCORE_W-1:0] results,
    output logic                    result_valid,
    output logic [PTR_W-1:0]        count,
    output logic                    full,
    output logic                    empty,
    output logic                    done,
    output logic                    overflow
);

    localparam int unsigned WIDTH  = ID_W + SCORE_W;
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             valid_q;
    logic             wr_accept, wr_drop, rd_accept;

    // Command decode; rd_ptr never exceeds count, so "not done" means rd_ptr < count.
    always_comb begin
        wr_accept = !clear && mode && wr_en && !full;
        wr_drop   = !clear && mode && wr_en && full;
        rd_accept = !clear && !rewind && !mode && rd_req && !done;
    end

    // Next-state for pointers and the sticky overflow flag.
    always_comb begin
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (clear) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
        end else begin
            if (rewind) begin
                rd_ptr_d = '0;
            end else if (rd_accept) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (wr_accept) begin
                count_d = count_q + PTR_W'(1);
            end
            if (wr_drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    // State registers; reset aborts any in-flight command.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            valid_q    <= rd_accept;
        end
    end

    // The memory's read register doubles as the results register.
    score_log_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_accept),
        .wr_addr (count_q[ADDR_W-1:0]),
        .wr_data ({who, score}),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr_q[ADDR_W-1:0]),
        .rd_data (results)
    );

    assign result_valid = valid_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign full         = (count_q == PTR_W'(DEPTH));
    assign empty        = (count_q == '0);
    assign done         = (rd_ptr_q == count_q);

endmodule

// File: tb/tb_score_log.sv
// Directed bench for score_log: a default-depth instance (a) and a DEPTH=4
// instance (b) share one stimulus stream; each step checks hand-computed values.
module tb_score_log;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode, wr_en, rd_req, rewind, clear;
    logic [3:0]  who;
    logic [7:0]  score;

    logic [11:0] a_results, b_results;
    logic        a_valid, b_valid;
    logic [4:0]  a_count;
    logic [2:0]  b_count;
    logic        a_full, a_empty, a_done, a_ovf;
    logic        b_full, b_empty, b_done, b_ovf;

    int unsigned passes = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    score_log u_a (
        .clk (clk), .rst (rst), .mode (mode), .wr_en (wr_en), .who (who),
        .score (score), .rd_req (rd_req), .rewind (rewind), .clear (clear),
        .results (a_results), .result_valid (a_valid), .count (a_count),
        .full (a_full), .empty (a_empty), .done (a_done), .overflow (a_ovf)
    );

    score_log #(.DEPTH (4)) u_b (
        .clk (clk), .rst (rst), .mode (mode), .wr_en (wr_en), .who (who),
        .score (score), .rd_req (rd_req), .rewind (rewind), .clear (clear),
        .results (b_results), .result_valid (b_valid), .count (b_count),
        .full (b_full), .empty (b_empty), .done (b_done), .overflow (b_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; mode = 1'b0; wr_en = 1'b0; rd_req = 1'b0;
        rewind = 1'b0; clear = 1'b0; who = '0; score = '0;
        #12;
        chk("rst_results", a_results, 0);
        chk("rst_valid",   a_valid,   0);
        chk("rst_count",   a_count,   0);
        chk("rst_full",    a_full,    0);
        chk("rst_empty",   a_empty,   1);
        chk("rst_done",    a_done,    1);
        chk("rst_ovf",     a_ovf,     0);
        #2 rst = 1'b1;
        step();

        // Record three entries.
        mode = 1'b1; wr_en = 1'b1;
        who = 4'd1; score = 8'h10; step();
        chk("wr1_count", a_count, 1);
        chk("wr1_empty", a_empty, 0);
        who = 4'd2; score = 8'h20; step();
        who = 4'd3; score = 8'h30; step();
        chk("wr3_count", a_count, 3);
        chk("wr3_done",  a_done,  0);

        // Replay with rd_req held four cycles.
        wr_en = 1'b0; mode = 1'b0; rd_req = 1'b1;
        step();
        chk("rd1_res", a_results, 12'h110);
        chk("rd1_vld", a_valid,   1);
        step();
        chk("rd2_res", a_results, 12'h220);
        chk("rd2_vld", a_valid,   1);
        step();
        chk("rd3_res", a_results, 12'h330);
        chk("rd3_vld", a_valid,   1);
        step();
        chk("rd4_vld",   a_valid,   0);
        chk("rd4_res",   a_results, 12'h330);
        chk("rd4_done",  a_done,    1);
        chk("rd4_count", a_count,   3);
        rd_req = 1'b0;

        // Fill the DEPTH=4 instance past capacity.
        mode = 1'b1; wr_en = 1'b1;
        who = 4'd4; score = 8'h40; step();
        chk("b_full4",  b_full,  1);
        chk("b_cnt4",   b_count, 4);
        chk("b_ovf4",   b_ovf,   0);
        who = 4'd5; score = 8'h50; step();
        chk("b_cnt5",   b_count, 4);
        chk("b_ovf5",   b_ovf,   1);
        chk("a_cnt5",   a_count, 5);
        chk("a_full5",  a_full,  0);

        // Rewind both and replay five requests.
        wr_en = 1'b0; mode = 1'b0; rewind = 1'b1; step();
        chk("rw_b_done", b_done, 0);
        rewind = 1'b0; rd_req = 1'b1;
        step();
        chk("b_rp1", b_results, 12'h110);
        step();
        step();
        step();
        chk("b_rp4",  b_results, 12'h440);
        chk("a_rp4",  a_results, 12'h440);
        step();
        chk("b_rp5_vld", b_valid,   0);
        chk("b_rp5_res", b_results, 12'h440);
        chk("a_rp5_res", a_results, 12'h550);
        chk("a_rp5_vld", a_valid,   1);
        rd_req = 1'b0;

        // Clear wins over a simultaneous write.
        mode = 1'b1; wr_en = 1'b1; clear = 1'b1; who = 4'd7; score = 8'h77;
        step();
        chk("clr_count", a_count, 0);
        chk("clr_empty", a_empty, 1);
        chk("clr_ovf_b", b_ovf,   0);
        chk("clr_done",  a_done,  1);
        clear = 1'b0;

        // Fresh entries, then a record-mode read request that must be ignored.
        who = 4'd6; score = 8'h61; step();
        who = 4'd7; score = 8'h72; step();
        who = 4'd8; score = 8'h83; step();
        chk("re_count", a_count, 3);
        wr_en = 1'b0; rd_req = 1'b1; step();
        chk("rec_rd_ignored", a_valid, 0);

        // Partial replay, append, then resume.
        mode = 1'b0; step();
        chk("pr1_res", a_results, 12'h661);
        rd_req = 1'b0; mode = 1'b1; wr_en = 1'b1; who = 4'd4; score = 8'h40;
        step();
        chk("app_count", a_count, 4);
        wr_en = 1'b0; mode = 1'b0; rd_req = 1'b1;
        step();
        chk("pr2_res", a_results, 12'h772);
        step();
        chk("pr3_res", a_results, 12'h883);
        step();
        chk("pr4_res", a_results, 12'h440);
        step();
        chk("pr5_vld",  a_valid, 0);
        chk("pr5_done", a_done,  1);

        // Rewind blocks a same-cycle read; next read returns entry 0.
        rewind = 1'b1; step();
        chk("rw_vld",  a_valid, 0);
        chk("rw_res",  a_results, 12'h440);
        chk("rw_done", a_done,  0);
        rewind = 1'b0; step();
        chk("rw_rd_res", a_results, 12'h661);
        chk("rw_rd_vld", a_valid,   1);
        rd_req = 1'b0;

        // Rewind in record mode still accepts the write.
        mode = 1'b1; wr_en = 1'b1; rewind = 1'b1; who = 4'd9; score = 8'h94;
        step();
        chk("rwwr_count", a_count, 5);
        chk("rwwr_b_cnt", b_count, 4);
        chk("rwwr_b_ovf", b_ovf,   1);
        rewind = 1'b0; wr_en = 1'b0; mode = 1'b0; rd_req = 1'b1;
        step();
        chk("rwwr_rd0", a_results, 12'h661);
        step();
        chk("rwwr_rd1", a_results, 12'h772);

        // Asynchronous reset mid-replay.
        #3 rst = 1'b0;
        #1;
        chk("ar_res",   a_results, 0);
        chk("ar_vld",   a_valid,   0);
        chk("ar_count", a_count,   0);
        chk("ar_done",  a_done,    1);
        chk("ar_empty", a_empty,   1);
        chk("ar_b_ovf", b_ovf,     0);
        chk("ar_b_res", b_results, 0);
        #2 rst = 1'b1; rd_req = 1'b0;
        step();
        chk("post_count", a_count, 0);
        chk("post_done",  a_done,  1);
        chk("post_vld",   a_valid, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
